// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS external data-memory channels among NUM_CONSUMERS LSU requesters.
// Each channel claims one pending request round-robin, runs the mem handshake, and relays the result.
//   state          | meaning
//   IDLE           | free; may claim a pending request this edge
//   READ_WAITING   | mem_read_valid held until mem_read_ready
//   WRITE_WAITING  | mem_write_valid held until mem_write_ready
//   READ_RELAYING  | consumer_read_ready held until consumer drops read_valid
//   WRITE_RELAYING | consumer_write_ready held until consumer drops write_valid
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]             mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]             mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] ST_IDLE           = 3'd0;
  localparam logic [2:0] ST_READ_WAITING   = 3'd1;
  localparam logic [2:0] ST_WRITE_WAITING  = 3'd2;
  localparam logic [2:0] ST_READ_RELAYING  = 3'd3;
  localparam logic [2:0] ST_WRITE_RELAYING = 3'd4;

  logic [2:0]               state_q [NUM_CHANNELS];
  logic [2:0]               state_d [NUM_CHANNELS];
  logic [CW-1:0]            owner_q [NUM_CHANNELS];
  logic [CW-1:0]            owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
  logic [CW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NUM_CHANNELS-1:0]  mem_rd_valid_q, mem_rd_valid_d;
  logic [NUM_CHANNELS-1:0]  mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_BITS-1:0]     mem_rd_addr_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_rd_addr_d [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_wr_addr_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     mem_wr_addr_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_wr_data_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     mem_wr_data_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] cons_rd_ready_q, cons_rd_ready_d;
  logic [NUM_CONSUMERS-1:0] cons_wr_ready_q, cons_wr_ready_d;
  logic [DATA_BITS-1:0]     cons_rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     cons_rd_data_d [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]     c_rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     c_wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     c_wr_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     m_rd_data [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] write_req;

  // With the write path disabled, write requests are invisible to arbitration.
  assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_cons
    assign c_rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign c_wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign c_wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = cons_rd_data_q[g];
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign m_rd_data[g] = mem_read_data[g*DATA_BITS +: DATA_BITS];
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS] = mem_rd_addr_q[g];
    assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] =
        (WRITE_ENABLE != 0) ? mem_wr_addr_q[g] : '0;
    assign mem_write_data[g*DATA_BITS +: DATA_BITS] =
        (WRITE_ENABLE != 0) ? mem_wr_data_q[g] : '0;
  end

  assign mem_read_valid       = mem_rd_valid_q;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wr_valid_q : '0;
  assign consumer_read_ready  = cons_rd_ready_q;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? cons_wr_ready_q : '0;

  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic [CW-1:0]            sel;
    logic [CW-1:0]            cidx;
    logic                     found;
    int                       idx;
    int                       nxt;

    state_d         = state_q;
    owner_d         = owner_q;
    claimed_d       = claimed_q;
    rr_ptr_d        = rr_ptr_q;
    mem_rd_valid_d  = mem_rd_valid_q;
    mem_wr_valid_d  = mem_wr_valid_q;
    mem_rd_addr_d   = mem_rd_addr_q;
    mem_wr_addr_d   = mem_wr_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    cons_rd_ready_d = cons_rd_ready_q;
    cons_wr_ready_d = cons_wr_ready_q;
    cons_rd_data_d  = cons_rd_data_q;
    taken           = claimed_q;
    sel             = '0;
    cidx            = '0;
    found           = 1'b0;
    idx             = 0;
    nxt             = 0;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        ST_IDLE: begin
          // Lower-index channels mark their pick in 'taken' before later channels scan.
          found = 1'b0;
          sel   = '0;
          for (int j = 0; j < NUM_CONSUMERS; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            cidx = CW'(idx);
            if (!found && !taken[cidx] && (consumer_read_valid[cidx] || write_req[cidx])) begin
              found = 1'b1;
              sel   = cidx;
            end
          end
          if (found) begin
            taken[sel]     = 1'b1;
            claimed_d[sel] = 1'b1;
            owner_d[ch]    = sel;
            nxt            = int'(sel) + 1;
            if (nxt >= NUM_CONSUMERS) nxt = 0;
            rr_ptr_d       = CW'(nxt);
            if (consumer_read_valid[sel]) begin
              mem_rd_valid_d[ch] = 1'b1;
              mem_rd_addr_d[ch]  = c_rd_addr[sel];
              state_d[ch]        = ST_READ_WAITING;
            end else begin
              mem_wr_valid_d[ch] = 1'b1;
              mem_wr_addr_d[ch]  = c_wr_addr[sel];
              mem_wr_data_d[ch]  = c_wr_data[sel];
              state_d[ch]        = ST_WRITE_WAITING;
            end
          end
        end
        ST_READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            mem_rd_valid_d[ch] = 1'b0;
            if (consumer_read_valid[owner_q[ch]]) begin
              cons_rd_ready_d[owner_q[ch]] = 1'b1;
              cons_rd_data_d[owner_q[ch]]  = m_rd_data[ch];
              state_d[ch]                  = ST_READ_RELAYING;
            end else begin
              claimed_d[owner_q[ch]] = 1'b0;
              state_d[ch]            = ST_IDLE;
            end
          end
        end
        ST_WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            mem_wr_valid_d[ch] = 1'b0;
            if (write_req[owner_q[ch]]) begin
              cons_wr_ready_d[owner_q[ch]] = 1'b1;
              state_d[ch]                  = ST_WRITE_RELAYING;
            end else begin
              claimed_d[owner_q[ch]] = 1'b0;
              state_d[ch]            = ST_IDLE;
            end
          end
        end
        ST_READ_RELAYING: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            cons_rd_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]       = 1'b0;
            state_d[ch]                  = ST_IDLE;
          end
        end
        ST_WRITE_RELAYING: begin
          if (!write_req[owner_q[ch]]) begin
            cons_wr_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]       = 1'b0;
            state_d[ch]                  = ST_IDLE;
          end
        end
        default: state_d[ch] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]       <= ST_IDLE;
        owner_q[ch]       <= '0;
        mem_rd_addr_q[ch] <= '0;
        mem_wr_addr_q[ch] <= '0;
        mem_wr_data_q[ch] <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        cons_rd_data_q[c] <= '0;
      end
      claimed_q       <= '0;
      rr_ptr_q        <= '0;
      mem_rd_valid_q  <= '0;
      mem_wr_valid_q  <= '0;
      cons_rd_ready_q <= '0;
      cons_wr_ready_q <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      mem_wr_addr_q   <= mem_wr_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      cons_rd_data_q  <= cons_rd_data_d;
      claimed_q       <= claimed_d;
      rr_ptr_q        <= rr_ptr_d;
      mem_rd_valid_q  <= mem_rd_valid_d;
      mem_wr_valid_q  <= mem_wr_valid_d;
      cons_rd_ready_q <= cons_rd_ready_d;
      cons_wr_ready_q <= cons_wr_ready_d;
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter at default parameters (8 consumers, 2 channels).
module tb_mem_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  crv, cwv;
  logic [63:0] cra, cwa, cwd;
  logic [7:0]  crr, cwr;
  logic [63:0] crd;
  logic [1:0]  mrv, mrr, mwv, mwr;
  logic [15:0] mra, mrd, mwa, mwd;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_channel_arbiter dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = '0; mrd = '0; mwr = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (mrv !== 2'b00) begin miscompares++; $display("FAIL reset_mrv got=%b exp=00", mrv); end
    vectors++; if (mwv !== 2'b00) begin miscompares++; $display("FAIL reset_mwv got=%b exp=00", mwv); end
    vectors++; if (crr !== 8'h00) begin miscompares++; $display("FAIL reset_crr got=%h exp=00", crr); end
    vectors++; if (cwr !== 8'h00) begin miscompares++; $display("FAIL reset_cwr got=%h exp=00", cwr); end
  endtask

  task automatic test_single_read();
    do_reset();
    crv[3] = 1'b1; cra[31:24] = 8'h05;
    tick();
    vectors++; if (mrv !== 2'b01) begin miscompares++; $display("FAIL sr_grant_mrv got=%b exp=01", mrv); end
    vectors++; if (mra[7:0] !== 8'h05) begin miscompares++; $display("FAIL sr_addr got=%h exp=05", mra[7:0]); end
    tick(); tick(); tick();
    mrr = 2'b10; mrd = 16'hEE00;
    tick();
    mrr = 2'b00;
    vectors++; if (crr !== 8'h00) begin miscompares++; $display("FAIL sr_idle_ch_ready got=%h exp=00", crr); end
    vectors++; if (mrv !== 2'b01) begin miscompares++; $display("FAIL sr_hold_mrv got=%b exp=01", mrv); end
    mrr = 2'b01; mrd = 16'h002A;
    tick();
    mrr = 2'b00;
    vectors++; if (crr !== 8'h08) begin miscompares++; $display("FAIL sr_ready got=%h exp=08", crr); end
    vectors++; if (crd[31:24] !== 8'h2A) begin miscompares++; $display("FAIL sr_data got=%h exp=2a", crd[31:24]); end
    vectors++; if (mrv !== 2'b00) begin miscompares++; $display("FAIL sr_mrv_drop got=%b exp=00", mrv); end
    tick();
    vectors++; if (crr !== 8'h08) begin miscompares++; $display("FAIL sr_ready_hold got=%h exp=08", crr); end
    crv[3] = 1'b0;
    tick();
    vectors++; if (crr !== 8'h00) begin miscompares++; $display("FAIL sr_ready_release got=%h exp=00", crr); end
    vectors++; if (crd[31:24] !== 8'h2A) begin miscompares++; $display("FAIL sr_data_hold got=%h exp=2a", crd[31:24]); end
  endtask

  task automatic test_contention();
    logic [7:0] ea0, ea1, ed0, ed1, emask;
    do_reset();
    crv = 8'hFF;
    for (int i = 0; i < 8; i++) cra[i*8 +: 8] = 8'h10 + 8'(i);
    tick();
    for (int p = 0; p < 4; p++) begin
      ea0 = 8'h10 + 8'(2*p); ea1 = 8'h11 + 8'(2*p);
      ed0 = 8'hA0 + 8'(2*p); ed1 = 8'hA1 + 8'(2*p);
      emask = 8'b11 << (2*p);
      vectors++; if (mrv !== 2'b11) begin miscompares++; $display("FAIL ct_mrv pair=%0d got=%b exp=11", p, mrv); end
      vectors++; if (mra[7:0] !== ea0) begin miscompares++; $display("FAIL ct_addr0 pair=%0d got=%h exp=%h", p, mra[7:0], ea0); end
      vectors++; if (mra[15:8] !== ea1) begin miscompares++; $display("FAIL ct_addr1 pair=%0d got=%h exp=%h", p, mra[15:8], ea1); end
      mrr = 2'b11; mrd = {ed1, ed0};
      tick();
      mrr = 2'b00;
      vectors++; if (crr !== emask) begin miscompares++; $display("FAIL ct_ready pair=%0d got=%h exp=%h", p, crr, emask); end
      vectors++; if (crd[(2*p)*8 +: 8] !== ed0) begin miscompares++; $display("FAIL ct_data0 pair=%0d got=%h exp=%h", p, crd[(2*p)*8 +: 8], ed0); end
      vectors++; if (crd[(2*p+1)*8 +: 8] !== ed1) begin miscompares++; $display("FAIL ct_data1 pair=%0d got=%h exp=%h", p, crd[(2*p+1)*8 +: 8], ed1); end
      crv[2*p] = 1'b0; crv[2*p+1] = 1'b0;
      tick();
      vectors++; if (crr !== 8'h00) begin miscompares++; $display("FAIL ct_release pair=%0d got=%h exp=00", p, crr); end
      tick();
    end
    vectors++; if (mrv !== 2'b00) begin miscompares++; $display("FAIL ct_final_mrv got=%b exp=00", mrv); end
  endtask

  task automatic test_write();
    do_reset();
    cwv[5] = 1'b1; cwa[47:40] = 8'd20; cwd[47:40] = 8'h1A;
    tick();
    vectors++; if (mwv !== 2'b01) begin miscompares++; $display("FAIL wr_mwv got=%b exp=01", mwv); end
    vectors++; if (mwa[7:0] !== 8'd20) begin miscompares++; $display("FAIL wr_addr got=%h exp=14", mwa[7:0]); end
    vectors++; if (mwd[7:0] !== 8'h1A) begin miscompares++; $display("FAIL wr_data got=%h exp=1a", mwd[7:0]); end
    vectors++; if (mrv !== 2'b00) begin miscompares++; $display("FAIL wr_read_idle got=%b exp=00", mrv); end
    mrr = 2'b01;
    tick();
    mrr = 2'b00;
    vectors++; if (mwv !== 2'b01) begin miscompares++; $display("FAIL wr_cross_ready_mwv got=%b exp=01", mwv); end
    vectors++; if (cwr !== 8'h00 || crr !== 8'h00) begin miscompares++; $display("FAIL wr_cross_ready cwr=%h crr=%h exp=00/00", cwr, crr); end
    mwr = 2'b01;
    tick();
    mwr = 2'b00;
    vectors++; if (cwr !== 8'h20) begin miscompares++; $display("FAIL wr_ready got=%h exp=20", cwr); end
    vectors++; if (mwv !== 2'b00) begin miscompares++; $display("FAIL wr_mwv_drop got=%b exp=00", mwv); end
    cwv[5] = 1'b0;
    tick();
    vectors++; if (cwr !== 8'h00) begin miscompares++; $display("FAIL wr_release got=%h exp=00", cwr); end
  endtask

  task automatic test_wrap();
    do_reset();
    cra[47:40] = 8'h55; cra[63:56] = 8'h77; cra[23:16] = 8'h22; cra[7:0] = 8'h01;
    crv[5] = 1'b1;
    tick();
    mrr = 2'b01; tick(); mrr = 2'b00;
    crv[5] = 1'b0; tick();
    crv[7] = 1'b1; crv[2] = 1'b1;
    tick();
    vectors++; if (mra[7:0] !== 8'h77) begin miscompares++; $display("FAIL wrap_ch0 got=%h exp=77", mra[7:0]); end
    vectors++; if (mra[15:8] !== 8'h22) begin miscompares++; $display("FAIL wrap_ch1 got=%h exp=22", mra[15:8]); end
    mrr = 2'b11; tick(); mrr = 2'b00;
    crv = '0; tick();
    crv[7] = 1'b1;
    tick();
    vectors++; if (mrv !== 2'b01 || mra[7:0] !== 8'h77) begin miscompares++; $display("FAIL wrap_c7 mrv=%b addr=%h exp=01/77", mrv, mra[7:0]); end
    mrr = 2'b01; tick(); mrr = 2'b00;
    crv[7] = 1'b0; tick();
    crv[7] = 1'b1; crv[0] = 1'b1;
    tick();
    vectors++; if (mra[7:0] !== 8'h01) begin miscompares++; $display("FAIL wrap_first0 got=%h exp=01", mra[7:0]); end
    vectors++; if (mra[15:8] !== 8'h77) begin miscompares++; $display("FAIL wrap_then7 got=%h exp=77", mra[15:8]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    crv[2] = 1'b1; cra[23:16] = 8'h22;
    tick(); tick();
    reset = 1'b1;
    tick();
    vectors++; if (mrv !== 2'b00 || mwv !== 2'b00) begin miscompares++; $display("FAIL rm_valids mrv=%b mwv=%b exp=00/00", mrv, mwv); end
    vectors++; if (crr !== 8'h00 || cwr !== 8'h00) begin miscompares++; $display("FAIL rm_readies crr=%h cwr=%h exp=00/00", crr, cwr); end
    reset = 1'b0; crv[2] = 1'b0;
    mrr = 2'b01; mrd = 16'h0099;
    tick();
    mrr = 2'b00;
    vectors++; if (crr !== 8'h00) begin miscompares++; $display("FAIL rm_late_ready got=%h exp=00", crr); end
    vectors++; if (mrv !== 2'b00) begin miscompares++; $display("FAIL rm_late_mrv got=%b exp=00", mrv); end
  endtask

  task automatic test_abort();
    do_reset();
    crv[1] = 1'b1; cra[15:8] = 8'h3C;
    tick();
    crv[1] = 1'b0;
    tick();
    vectors++; if (mrv !== 2'b01) begin miscompares++; $display("FAIL ab_hold got=%b exp=01", mrv); end
    mrr = 2'b01;
    tick();
    mrr = 2'b00;
    vectors++; if (crr !== 8'h00 || mrv !== 2'b00) begin miscompares++; $display("FAIL ab_skip crr=%h mrv=%b exp=00/00", crr, mrv); end
    crv[1] = 1'b1;
    tick();
    vectors++; if (mrv !== 2'b01) begin miscompares++; $display("FAIL ab_regrant got=%b exp=01", mrv); end
  endtask

  task automatic test_read_write_same();
    do_reset();
    crv[4] = 1'b1; cra[39:32] = 8'h33;
    cwv[4] = 1'b1; cwa[39:32] = 8'h44; cwd[39:32] = 8'h55;
    tick();
    vectors++; if (mrv !== 2'b01 || mwv !== 2'b00) begin miscompares++; $display("FAIL rw_read_first mrv=%b mwv=%b exp=01/00", mrv, mwv); end
    vectors++; if (mra[7:0] !== 8'h33) begin miscompares++; $display("FAIL rw_raddr got=%h exp=33", mra[7:0]); end
    mrr = 2'b01; mrd = 16'h0066;
    tick();
    mrr = 2'b00;
    vectors++; if (crr !== 8'h10 || cwr !== 8'h00) begin miscompares++; $display("FAIL rw_read_done crr=%h cwr=%h exp=10/00", crr, cwr); end
    vectors++; if (crd[39:32] !== 8'h66) begin miscompares++; $display("FAIL rw_rdata got=%h exp=66", crd[39:32]); end
    crv[4] = 1'b0;
    tick();
    vectors++; if (crr !== 8'h00 || mwv !== 2'b00) begin miscompares++; $display("FAIL rw_gap crr=%h mwv=%b exp=00/00", crr, mwv); end
    tick();
    vectors++; if (mwv !== 2'b01) begin miscompares++; $display("FAIL rw_write_grant got=%b exp=01", mwv); end
    vectors++; if (mwa[7:0] !== 8'h44 || mwd[7:0] !== 8'h55) begin miscompares++; $display("FAIL rw_wpayload addr=%h data=%h exp=44/55", mwa[7:0], mwd[7:0]); end
    mwr = 2'b01;
    tick();
    mwr = 2'b00;
    vectors++; if (cwr !== 8'h10) begin miscompares++; $display("FAIL rw_write_done got=%h exp=10", cwr); end
    cwv[4] = 1'b0;
    tick();
    vectors++; if (cwr !== 8'h00) begin miscompares++; $display("FAIL rw_write_release got=%h exp=00", cwr); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_wrap();
    test_reset_mid();
    test_abort();
    test_read_write_same();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
